// File: rtl/dkong_sync_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : dkong_sync_decoder_pkg
// Brief  : Shared definitions for the video sync decoder: counter widths,
//          saturation limits, lock-FSM state encoding and a small helper.
// Rev    : 1.0  initial release
// ============================================================================
package dkong_sync_decoder_pkg;

  localparam int H_W = 11;                 // horizontal position / line length width
  localparam int V_W = 9;                  // vertical position / frame line count width

  localparam logic [H_W-1:0] H_MAX = 11'd2047;  // O_H_POS saturation (sync loss)
  localparam logic [V_W-1:0] V_MAX = 9'd511;    // O_V_POS saturation

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;

  // Magnitude of the difference between two line lengths.
  function automatic logic [H_W-1:0] abs_diff_h(input logic [H_W-1:0] a,
                                                input logic [H_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dkong_sync_decoder_edge.sv
`default_nettype none
// ============================================================================
// Module : dkong_sync_edge
// Brief  : Two-stage input register with a falling-edge pulse on an
//          active-low sync input. Both stages reset high so an idle (high)
//          input never produces a spurious edge after reset.
// Ports  : clk     in  rising-edge clock
//          rst_n   in  synchronous active-low reset
//          sync_n  in  raw active-low sync input
//          fall    out one-clock pulse, stage1 low while stage2 still high
// Rev    : 1.0  initial release
// ============================================================================
module dkong_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_n,
  output logic fall
);

  logic stage1;
  logic stage2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1 <= 1'b1;
      stage2 <= 1'b1;
    end else begin
      stage1 <= sync_n;
      stage2 <= stage1;
    end
  end

  assign fall = stage2 & ~stage1;

endmodule
`default_nettype wire

// File: rtl/dkong_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module : dkong_sync_decoder
// Brief  : Measures incoming video timing (line length, lines per frame),
//          tracks beam position and declares lock once line and frame timing
//          have been stable for a configurable number of lines/frames.
// Ports  : I_CLK          in   clock (24.576 MHz nominal)
//          RST_n          in   synchronous active-low reset
//          I_H_SYNCn      in   active-low horizontal sync
//          I_V_SYNCn      in   active-low vertical sync
//          I_H_BLANKn     in   active-low horizontal blank
//          I_V_BLANKn     in   active-low vertical blank
//          O_H_POS        out  clocks since last HSYNC falling edge (sat 2047)
//          O_V_POS        out  lines since frame start (sat 511)
//          O_LINE_LEN     out  last measured line length
//          O_FRAME_LINES  out  last measured lines per frame
//          O_LOCKED       out  lock FSM in LOCKED
//          O_DE           out  registered H_BLANKn & V_BLANKn
//          O_LINE_STB     out  one-clock pulse per line start
//          O_FRAME_STB    out  one-clock pulse per frame start
// Rev    : 1.0  initial release
// ============================================================================
module dkong_sync_decoder
  import dkong_sync_decoder_pkg::*;
#(
  parameter int H_TOL       = 1,
  parameter int LOCK_LINES  = 4,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           I_CLK,
  input  logic           RST_n,
  input  logic           I_H_SYNCn,
  input  logic           I_V_SYNCn,
  input  logic           I_H_BLANKn,
  input  logic           I_V_BLANKn,
  output logic [H_W-1:0] O_H_POS,
  output logic [V_W-1:0] O_V_POS,
  output logic [H_W-1:0] O_LINE_LEN,
  output logic [V_W-1:0] O_FRAME_LINES,
  output logic           O_LOCKED,
  output logic           O_DE,
  output logic           O_LINE_STB,
  output logic           O_FRAME_STB
);

  localparam int LM_W = $clog2(LOCK_LINES + 1);
  localparam int FM_W = $clog2(LOCK_FRAMES + 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic h_fall;
  logic v_fall;
  logic h_blank_q;
  logic v_blank_q;

  dkong_sync_edge u_hsync_edge (
    .clk    (I_CLK),
    .rst_n  (RST_n),
    .sync_n (I_H_SYNCn),
    .fall   (h_fall)
  );

  dkong_sync_edge u_vsync_edge (
    .clk    (I_CLK),
    .rst_n  (RST_n),
    .sync_n (I_V_SYNCn),
    .fall   (v_fall)
  );

  always_ff @(posedge I_CLK) begin
    if (!RST_n) begin
      h_blank_q <= 1'b0;
      v_blank_q <= 1'b0;
    end else begin
      h_blank_q <= I_H_BLANKn;
      v_blank_q <= I_V_BLANKn;
    end
  end

  // --------------------------------------------------------------------------
  // Position counters and measurements
  // --------------------------------------------------------------------------
  logic           v_pending;
  logic           frame_evt;
  logic [H_W-1:0] new_len;
  logic [V_W-1:0] new_frames;

  // A VSYNC edge arriving on the same clock as HSYNC counts as already
  // pending, so that HSYNC edge restarts the frame.
  assign frame_evt  = h_fall & (v_pending | v_fall);
  assign new_len    = O_H_POS + 11'd1;
  assign new_frames = O_V_POS + 9'd1;

  always_ff @(posedge I_CLK) begin
    if (!RST_n) begin
      O_H_POS       <= '0;
      O_V_POS       <= '0;
      O_LINE_LEN    <= '0;
      O_FRAME_LINES <= '0;
      O_LINE_STB    <= 1'b0;
      O_FRAME_STB   <= 1'b0;
      O_DE          <= 1'b0;
      v_pending     <= 1'b0;
    end else begin
      O_LINE_STB  <= h_fall;
      O_FRAME_STB <= frame_evt;
      O_DE        <= h_blank_q & v_blank_q;

      if (h_fall) begin
        O_LINE_LEN <= new_len;
        O_H_POS    <= '0;
        if (frame_evt) begin
          O_FRAME_LINES <= new_frames;
          O_V_POS       <= '0;
        end else if (O_V_POS != V_MAX) begin
          O_V_POS <= new_frames;
        end
      end else if (O_H_POS != H_MAX) begin
        O_H_POS <= new_len;
      end

      if (frame_evt) begin
        v_pending <= 1'b0;
      end else if (v_fall) begin
        v_pending <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lock FSM
  // --------------------------------------------------------------------------
  lock_state_e     state;
  lock_state_e     state_nxt;
  logic [LM_W-1:0] line_match;
  logic [LM_W-1:0] line_match_nxt;
  logic [FM_W-1:0] frame_match;
  logic [FM_W-1:0] frame_match_nxt;
  logic [H_W-1:0]  ref_len;
  logic [H_W-1:0]  ref_len_nxt;
  logic [V_W-1:0]  ref_frames;
  logic [V_W-1:0]  ref_frames_nxt;
  logic            sync_loss;
  logic [H_W-1:0]  len_dev;

  assign sync_loss = (O_H_POS == H_MAX);
  assign len_dev   = abs_diff_h(new_len, ref_len);
  assign O_LOCKED  = (state == ST_LOCKED);

  always_ff @(posedge I_CLK) begin
    if (!RST_n) begin
      state       <= ST_SEARCH;
      line_match  <= '0;
      frame_match <= '0;
      ref_len     <= '0;
      ref_frames  <= '0;
    end else begin
      state       <= state_nxt;
      line_match  <= line_match_nxt;
      frame_match <= frame_match_nxt;
      ref_len     <= ref_len_nxt;
      ref_frames  <= ref_frames_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    line_match_nxt  = line_match;
    frame_match_nxt = frame_match;
    ref_len_nxt     = ref_len;
    ref_frames_nxt  = ref_frames;

    case (state)
      ST_SEARCH: begin
        if (h_fall) begin
          state_nxt       = ST_ACQUIRE;
          line_match_nxt  = '0;
          frame_match_nxt = '0;
        end
      end

      ST_ACQUIRE: begin
        if (sync_loss) begin
          state_nxt = ST_SEARCH;
        end else begin
          // O_LINE_LEN / O_FRAME_LINES still hold the previous measurement
          // on the clock a new one is taken.
          if (h_fall) begin
            if (new_len == O_LINE_LEN) begin
              if (line_match != LM_W'(LOCK_LINES)) begin
                line_match_nxt = line_match + LM_W'(1);
              end
            end else begin
              line_match_nxt = '0;
            end
          end
          if (frame_evt) begin
            if (new_frames == O_FRAME_LINES) begin
              if (frame_match != FM_W'(LOCK_FRAMES)) begin
                frame_match_nxt = frame_match + FM_W'(1);
              end
            end else begin
              frame_match_nxt = FM_W'(1);
            end
          end
          if ((line_match_nxt == LM_W'(LOCK_LINES)) &&
              (frame_match_nxt == FM_W'(LOCK_FRAMES))) begin
            state_nxt      = ST_LOCKED;
            ref_len_nxt    = h_fall ? new_len : O_LINE_LEN;
            ref_frames_nxt = frame_evt ? new_frames : O_FRAME_LINES;
          end
        end
      end

      ST_LOCKED: begin
        if (sync_loss ||
            (h_fall && (len_dev > H_W'(H_TOL))) ||
            (frame_evt && (new_frames != ref_frames))) begin
          state_nxt = ST_SEARCH;
        end
      end

      default: begin
        state_nxt = ST_SEARCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dkong_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_dkong_sync_decoder
// Brief  : Directed bench for dkong_sync_decoder. Video is generated with
//          short lines (16 clocks, HSYNC low 4) and 264-line frames; a few
//          1536-clock lines exercise the full-length measurement.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dkong_sync_decoder;

  localparam int HLOW = 4;
  localparam int LEN  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs_n, vs_n, hb_n, vb_n;
  logic [10:0] h_pos, line_len;
  logic [8:0]  v_pos, frame_lines;
  logic        locked, de, line_stb, frame_stb;

  int   total = 0;
  int   bad   = 0;
  int   stb_seen = 0;
  logic locked_at_stb [0:7];
  logic ever_locked = 1'b0;

  always #5 clk = ~clk;

  dkong_sync_decoder #(
    .H_TOL       (1),
    .LOCK_LINES  (4),
    .LOCK_FRAMES (2)
  ) dut (
    .I_CLK         (clk),
    .RST_n         (rst_n),
    .I_H_SYNCn     (hs_n),
    .I_V_SYNCn     (vs_n),
    .I_H_BLANKn    (hb_n),
    .I_V_BLANKn    (vb_n),
    .O_H_POS       (h_pos),
    .O_V_POS       (v_pos),
    .O_LINE_LEN    (line_len),
    .O_FRAME_LINES (frame_lines),
    .O_LOCKED      (locked),
    .O_DE          (de),
    .O_LINE_STB    (line_stb),
    .O_FRAME_STB   (frame_stb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (locked === 1'b1) ever_locked = 1'b1;
    if (frame_stb === 1'b1) begin
      if (stb_seen < 8) locked_at_stb[stb_seen] = locked;
      stb_seen++;
    end
  endtask

  task automatic send_line_part(input int from, input int len, input bit vs);
    for (int i = from; i < len; i++) begin
      hs_n = (i < HLOW) ? 1'b0 : 1'b1;
      vs_n = (vs && (i < HLOW)) ? 1'b0 : 1'b1;
      step();
    end
  endtask

  task automatic send_line(input int len, input bit vs);
    send_line_part(0, len, vs);
  endtask

  task automatic send_frame(input int nlines);
    send_line(LEN, 1'b1);
    for (int l = 1; l < nlines; l++) send_line(LEN, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    hs_n = 1'b1; vs_n = 1'b1; hb_n = 1'b1; vb_n = 1'b1;
    for (int k = 0; k < 8; k++) locked_at_stb[k] = 1'bx;

    // ---------------- reset state ----------------
    step(); step(); step();
    check("rst_h_pos", h_pos, 0);
    check("rst_v_pos", v_pos, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_locked", locked, 0);
    check("rst_de", de, 0);
    check("rst_line_stb", line_stb, 0);
    check("rst_frame_stb", frame_stb, 0);

    rst_n = 1'b1;
    step();
    check("post_rst_h_pos1", h_pos, 1);
    check("post_rst_de_lat", de, 0);
    check("post_rst_no_edge", line_stb, 0);
    step();
    check("post_rst_h_pos2", h_pos, 2);
    check("de_rise", de, 1);
    vb_n = 1'b0;
    step();
    check("de_hold", de, 1);
    step();
    check("de_fall", de, 0);
    vb_n = 1'b1;
    step(); step();

    // ---------------- acquire and lock over three frames ----------------
    send_frame(264);
    send_frame(264);
    send_frame(264);
    check("acq_stb_count", stb_seen, 3);
    check("acq_lock_stb1", locked_at_stb[0], 0);
    check("acq_lock_stb2", locked_at_stb[1], 0);
    check("acq_lock_stb3", locked_at_stb[2], 1);
    check("acq_line_len", line_len, 16);
    check("acq_frame_lines", frame_lines, 264);
    check("acq_h_pos", h_pos, 14);
    check("acq_v_pos", v_pos, 263);

    // ---------------- HSYNC+VSYNC same clock ----------------
    send_line_part(0, 2, 1'b1);
    check("sim_frame_stb", frame_stb, 1);
    check("sim_v_pos", v_pos, 0);
    check("sim_line_stb", line_stb, 1);
    check("sim_h_pos", h_pos, 0);
    check("sim_locked", locked, 1);
    send_line_part(2, LEN, 1'b1);
    for (int l = 1; l < 10; l++) send_line(LEN, 1'b0);

    // one clock short: within tolerance
    send_line(LEN - 1, 1'b0);
    send_line_part(0, 2, 1'b0);
    check("tol_line_len", line_len, 15);
    check("tol_locked", locked, 1);
    send_line_part(2, LEN, 1'b0);
    for (int l = 12; l < 20; l++) send_line(LEN, 1'b0);

    // three clocks short: lock lost two clocks after the HSYNC edge
    send_line(LEN - 3, 1'b0);
    send_line_part(0, 1, 1'b0);
    check("loss_lock_1clk", locked, 1);
    send_line_part(1, 2, 1'b0);
    check("loss_lock_2clk", locked, 0);
    check("loss_line_len", line_len, 13);
    send_line_part(2, LEN, 1'b0);
    for (int l = 22; l < 264; l++) send_line(LEN, 1'b0);

    // relock: one matching frame, then a second
    stb_seen = 0;
    send_frame(264);
    send_line(LEN, 1'b1);
    check("relock_stb1", locked_at_stb[0], 0);
    check("relock_stb2", locked_at_stb[1], 1);

    // ---------------- one-clock reset mid-line while locked ----------------
    for (int l = 1; l < 5; l++) send_line(LEN, 1'b0);
    send_line_part(0, 8, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid_rst_h_pos", h_pos, 0);
    check("mid_rst_v_pos", v_pos, 0);
    check("mid_rst_line_len", line_len, 0);
    check("mid_rst_frame_lines", frame_lines, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_de", de, 0);
    check("mid_rst_line_stb", line_stb, 0);
    check("mid_rst_frame_stb", frame_stb, 0);
    rst_n = 1'b1;
    stb_seen = 0;
    send_line_part(8, LEN, 1'b0);
    for (int l = 6; l < 264; l++) send_line(LEN, 1'b0);
    send_frame(264);
    send_frame(264);
    send_line(LEN, 1'b1);
    check("rst_relock_count", stb_seen, 3);
    check("rst_relock_stb1", locked_at_stb[0], 0);
    check("rst_relock_stb2", locked_at_stb[1], 0);
    check("rst_relock_stb3", locked_at_stb[2], 1);

    // ---------------- HSYNC stuck high ----------------
    for (int l = 1; l < 4; l++) send_line(LEN, 1'b0);
    hs_n = 1'b1;
    vs_n = 1'b1;
    for (int k = 0; k < 2100; k++) step();
    check("stuck_h_pos", h_pos, 2047);
    check("stuck_locked", locked, 0);
    check("stuck_line_stb", line_stb, 0);

    // ---------------- alternating 264/263 frames ----------------
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    ever_locked = 1'b0;
    stb_seen = 0;
    send_frame(264);
    send_frame(263);
    send_frame(264);
    send_frame(263);
    send_line(LEN, 1'b1);
    check("alt_stb_count", stb_seen, 5);
    check("alt_frame_lines", frame_lines, 263);
    check("alt_never_locked", ever_locked, 0);

    // ---------------- full-length 1536-clock lines ----------------
    send_line(1536, 1'b0);
    send_line(1536, 1'b0);
    send_line_part(0, 2, 1'b0);
    check("long_line_len", line_len, 1536);
    check("long_line_stb", line_stb, 1);
    check("long_h_pos", h_pos, 0);
    check("long_v_pos", v_pos, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dkong_sync_decoder.md
DKONG_SYNC_DECODER -- requirements
Module: dkong_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOL, default 1, meaning max line-length deviation (clocks) tolerated while locked.
REQ-002 SHALL have parameter LOCK_LINES, default 4, meaning consecutive matching lines required for line lock.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive equal frame-line counts required for frame lock.
REQ-004 SHALL have port I_CLK  in  1  single clock; all logic on its rising edge (24.576MHz nominal).
REQ-005 SHALL have port RST_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports I_H_SYNCn, I_V_SYNCn, I_H_BLANKn, I_V_BLANKn  in  1 each  incoming active-low video timing.
REQ-007 SHALL have port O_H_POS  out  11  clocks since last HSYNC falling edge.
REQ-008 SHALL have port O_V_POS  out  9  lines since last frame start.
REQ-009 SHALL have port O_LINE_LEN  out  11  last measured line length in clocks.
REQ-010 SHALL have port O_FRAME_LINES  out  9  last measured lines per frame.
REQ-011 SHALL have ports O_LOCKED  out  1  and O_DE  out  1 (registered I_H_BLANKn & I_V_BLANKn).
REQ-012 SHALL have ports O_LINE_STB, O_FRAME_STB  out  1 each  one-clock pulses.

Function
REQ-013 All four inputs SHALL be registered once; edges SHALL be detected against a second register; outputs respond 2 clocks after an input edge.
REQ-014 On HSYNC falling edge: O_LINE_LEN <= O_H_POS+1, O_H_POS <= 0, O_LINE_STB pulses, O_V_POS increments (saturating at 511).
REQ-015 Otherwise O_H_POS SHALL increment each clock, saturating at 2047.
REQ-016 A VSYNC falling edge SHALL set a pending flag; at the next HSYNC falling edge: O_FRAME_LINES <= O_V_POS+1, O_V_POS <= 0, O_FRAME_STB pulses, flag clears.
REQ-017 VSYNC and HSYNC falling on the same clock SHALL be treated as VSYNC first (frame restart on that edge).
REQ-018 Lock FSM states SEARCH, ACQUIRE, LOCKED; O_LOCKED = (state==LOCKED).
REQ-019 SEARCH -> ACQUIRE on first HSYNC falling edge; line-match counter cleared.
REQ-020 In ACQUIRE, each line whose length equals the previous one SHALL increment the line-match count (sat. LOCK_LINES); a mismatch clears it.
REQ-021 In ACQUIRE, each frame whose line count equals the previous one SHALL increment the frame-match count (sat. LOCK_FRAMES); a mismatch clears it to 1.
REQ-022 ACQUIRE -> LOCKED when both counts reach their thresholds; reference line length and frame lines captured at that moment.
REQ-023 LOCKED -> SEARCH when a line differs from reference by more than H_TOL, a frame line count differs from reference, or O_H_POS reaches 2047 (sync loss).
REQ-024 ACQUIRE -> SEARCH on O_H_POS reaching 2047.
REQ-025 O_DE SHALL follow the registered blank inputs independent of lock state.

Reset
REQ-026 While RST_n low at a clock edge: all counters, O_LINE_LEN, O_FRAME_LINES, strobes, O_DE, O_LOCKED = 0; FSM = SEARCH; edge registers = 1 (no false edge after reset).
REQ-027 Reset mid-frame SHALL discard partial measurements; first O_LINE_LEN after reset is not a valid line until the second HSYNC edge.

Structure
REQ-028 State encoding, width constants (11, 9) and the 2047 saturation value SHALL live in the shared dkong package.
REQ-029 A sub-module dkong_sync_edge (two-stage register plus falling-edge pulse) SHALL be instantiated per sync input.

Verification
REQ-030 Lines of 1536 clocks (HSYNC low 128), 264 lines/frame -> O_LINE_LEN=1536, O_FRAME_LINES=264, O_LOCKED=1 by the third FRAME_STB.
REQ-031 Locked, one line shortened to 1535 -> stays locked; shortened to 1533 -> O_LOCKED=0 two clocks after that HSYNC edge.
REQ-032 Locked, HSYNC held high -> O_H_POS saturates at 2047, O_LOCKED=0, FSM SEARCH.
REQ-033 HSYNC and VSYNC falling on same clock -> O_V_POS=0 and O_FRAME_STB=1 together.
REQ-034 RST_n low for 1 clock mid-line while locked -> all outputs 0, relock after LOCK_FRAMES+1 frames.
REQ-035 Alternating frame lengths 264/263 -> never LOCKED.
